// File: rtl/ssram_pkg.sv
// Shared opcodes, mode encodings and FSM states for the serial SRAM responder.
package ssram_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_RDMR  = 8'h05;
  localparam logic [7:0] CMD_WRMR  = 8'h01;
  localparam logic [7:0] CMD_EQIO  = 8'h38;
  localparam logic [7:0] CMD_RSTIO = 8'hFF;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_PAGE = 2'b10;
  localparam logic [1:0] MODE_SEQ  = 2'b01;
  localparam logic [7:0] MODE_RST  = 8'h40;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_RDATA, ST_WDATA, ST_RDMR, ST_WRMR, ST_IGNORE
  } state_t;

endpackage

// File: rtl/ssram_edge_sync.sv
// Multi-stage synchronizer with one-clk rise/fall pulses on the synchronized level.
module ssram_edge_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              q_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= {STAGES{RST_VAL}};
      q_d  <= RST_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      q_d  <= sync[STAGES-1];
    end
  end

  assign rise = sync[STAGES-1] & ~q_d;
  assign fall = ~sync[STAGES-1] & q_d;

endmodule

// File: rtl/ssram_responder.sv
// 23LC512-style serial SRAM slave backed by a synchronous RAM port.
// Define SSRAM_SQI_EN to add quad (SQI) mode via EQIO/RSTIO.
module ssram_responder
  import ssram_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int PAGE_BYTES  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sck_in,
  input  logic              csb_in,
  input  logic [3:0]        sio_in,
  output logic [3:0]        sio_out,
  output logic [3:0]        sio_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        mode_reg,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] PMASK = ADDR_W'(PAGE_BYTES - 1);

  logic sck_rise, sck_fall, csb_rise, csb_fall;

  ssram_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .reset(reset), .d(sck_in), .rise(sck_rise), .fall(sck_fall));
  ssram_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csb (
    .clk(clk), .reset(reset), .d(csb_in), .rise(csb_rise), .fall(csb_fall));

  // Data pads use the same depth as sck so SI is aligned with the sck rise pulse.
  logic [SYNC_STAGES-1:0][3:0] sio_sync;
  logic [3:0]                  sio_s;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sio_sync <= '0;
    else        sio_sync <= {sio_sync[SYNC_STAGES-2:0], sio_in};
  end
  assign sio_s = sio_sync[SYNC_STAGES-1];

  state_t            state, state_nx;
  logic [4:0]        bit_cnt, cnt_nx, cnt_inc, step;
  logic [7:0]        shreg, sh_nx, bits_in;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic              is_rd, rd_nx;
  logic [7:0]        out_sr, osr_nx;
  logic [1:0]        dcnt, dcnt_nx;
  logic              ld_q;
  logic [3:0]        so_q, so_nx, oe_q, oe_nx;
  logic [7:0]        mode_q, mode_nx;
  logic [ADDR_W-1:0] maddr_q, maddr_nx;
  logic [7:0]        wdata_q, wdata_nx;
  logic              we_q, we_nx, re_q, re_nx;
  logic              quad;

`ifdef SSRAM_SQI_EN
  logic quad_q, quad_nx;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) quad_q <= 1'b0;
    else        quad_q <= quad_nx;
  end
  assign quad = quad_q;
`else
  assign quad = 1'b0;
`endif

  function automatic logic [ADDR_W-1:0] addr_adv(input logic [ADDR_W-1:0] a,
                                                 input logic [1:0] m);
    logic [ADDR_W-1:0] inc;
    inc = a + 1'b1;
    case (m)
      MODE_BYTE: return a;
      MODE_PAGE: return (a & ~PMASK) | (inc & PMASK);
      default:   return inc;  // sequential and reserved
    endcase
  endfunction

  always_comb begin
    state_nx = state;
    cnt_nx   = bit_cnt;
    sh_nx    = shreg;
    addr_nx  = addr_q;
    rd_nx    = is_rd;
    osr_nx   = out_sr;
    dcnt_nx  = dcnt;
    so_nx    = so_q;
    oe_nx    = oe_q;
    mode_nx  = mode_q;
    maddr_nx = maddr_q;
    wdata_nx = wdata_q;
    we_nx    = 1'b0;
    re_nx    = 1'b0;
`ifdef SSRAM_SQI_EN
    quad_nx  = quad_q;
`endif
    step    = quad ? 5'd4 : 5'd1;
    cnt_inc = bit_cnt + step;
    bits_in = quad ? {shreg[3:0], sio_s} : {shreg[6:0], sio_s[0]};

    case (state)
      ST_IDLE: if (csb_fall) begin
        state_nx = ST_CMD;
        cnt_nx   = '0;
      end
      ST_CMD: if (sck_rise) begin
        sh_nx  = bits_in;
        cnt_nx = cnt_inc;
        if (cnt_inc == 5'd8) begin
          cnt_nx = '0;
          case (bits_in)
            CMD_READ:  begin state_nx = ST_ADDR; rd_nx = 1'b1; end
            CMD_WRITE: begin state_nx = ST_ADDR; rd_nx = 1'b0; end
            CMD_RDMR:  begin state_nx = ST_RDMR; osr_nx = mode_q; end
            CMD_WRMR:  state_nx = ST_WRMR;
`ifdef SSRAM_SQI_EN
            CMD_EQIO:  begin state_nx = ST_IGNORE; quad_nx = 1'b1; end
            CMD_RSTIO: begin state_nx = ST_IGNORE; quad_nx = 1'b0; end
`endif
            default:   state_nx = ST_IGNORE;
          endcase
        end
      end
      ST_ADDR: if (sck_rise) begin
        addr_nx = quad ? {addr_q[ADDR_W-5:0], sio_s} : {addr_q[ADDR_W-2:0], sio_s[0]};
        cnt_nx  = cnt_inc;
        if (cnt_inc == 5'd16) begin
          cnt_nx = '0;
          if (is_rd) begin
            state_nx = ST_RDATA;
            re_nx    = 1'b1;
            maddr_nx = addr_nx;
            dcnt_nx  = quad ? 2'd2 : 2'd0;  // quad reads skip one dummy byte
          end else begin
            state_nx = ST_WDATA;
          end
        end
      end
      ST_RDATA, ST_RDMR: begin
        if (ld_q && state == ST_RDATA) osr_nx = mem_rdata;
        if (sck_fall) begin
          if (dcnt != 2'd0) begin
            dcnt_nx = dcnt - 2'd1;
          end else begin
            if (quad) begin
              so_nx  = out_sr[7:4];
              oe_nx  = 4'hF;
              osr_nx = {out_sr[3:0], 4'h0};
            end else begin
              so_nx  = {2'b00, out_sr[7], 1'b0};
              oe_nx  = 4'b0010;
              osr_nx = {out_sr[6:0], 1'b0};
            end
            cnt_nx = cnt_inc;
            // Last bit of the byte is on the pad: fetch the next byte during the bit time.
            if (cnt_inc == 5'd8) begin
              cnt_nx = '0;
              if (state == ST_RDMR) begin
                osr_nx = mode_q;
              end else begin
                addr_nx  = addr_adv(addr_q, mode_q[7:6]);
                maddr_nx = addr_nx;
                re_nx    = 1'b1;
              end
            end
          end
        end
      end
      ST_WDATA: if (sck_rise) begin
        sh_nx  = bits_in;
        cnt_nx = cnt_inc;
        if (cnt_inc == 5'd8) begin
          cnt_nx   = '0;
          we_nx    = 1'b1;
          maddr_nx = addr_q;
          wdata_nx = bits_in;
          addr_nx  = addr_adv(addr_q, mode_q[7:6]);
        end
      end
      ST_WRMR: if (sck_rise && bit_cnt < 5'd8) begin
        sh_nx  = bits_in;
        cnt_nx = cnt_inc;
        if (cnt_inc == 5'd8) mode_nx = {bits_in[7:6], 6'b0};
      end
      default: ;
    endcase

    // Abort after the coincident sck edge has been handled above.
    if (csb_rise) begin
      state_nx = ST_IDLE;
      so_nx    = '0;
      oe_nx    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      addr_q  <= '0;
      is_rd   <= 1'b0;
      out_sr  <= '0;
      dcnt    <= '0;
      ld_q    <= 1'b0;
      so_q    <= '0;
      oe_q    <= '0;
      mode_q  <= MODE_RST;
      maddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      state   <= state_nx;
      bit_cnt <= cnt_nx;
      shreg   <= sh_nx;
      addr_q  <= addr_nx;
      is_rd   <= rd_nx;
      out_sr  <= osr_nx;
      dcnt    <= dcnt_nx;
      ld_q    <= re_q;
      so_q    <= so_nx;
      oe_q    <= oe_nx;
      mode_q  <= mode_nx;
      maddr_q <= maddr_nx;
      wdata_q <= wdata_nx;
      we_q    <= we_nx;
      re_q    <= re_nx;
    end
  end

`ifdef SSRAM_SQI_EN
  assign sio_out = so_q;
  assign sio_oe  = oe_q;
`else
  assign sio_out = so_q & 4'b0010;
  assign sio_oe  = oe_q & 4'b0010;
`endif

  assign mem_addr  = maddr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign mem_re    = re_q;
  assign mode_reg  = mode_q;
  assign busy      = (state != ST_IDLE) && (state != ST_IGNORE);

endmodule

// File: tb/tb_ssram_responder.sv
// Randomized SPI-master bench for ssram_responder with a behavioural memory/mode model.
module tb_ssram_responder;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        reset, sck_in, csb_in;
  logic [3:0]  sio_in, sio_out, sio_oe;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata, mode_reg;
  logic        mem_we, mem_re, busy;

  ssram_responder dut (
    .clk(clk), .reset(reset), .sck_in(sck_in), .csb_in(csb_in), .sio_in(sio_in),
    .sio_out(sio_out), .sio_oe(sio_oe), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .mode_reg(mode_reg),
    .busy(busy));

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  logic [7:0]  ram     [0:65535];
  logic [7:0]  exp_mem [0:65535];
  logic [23:0] we_q[$];
  logic [15:0] re_q[$];
  logic [7:0]  model_mode = 8'h40;
  logic        quad_m = 1'b0;

  // Backing RAM: the environment, not the reference.
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      we_q.push_back({mem_addr, mem_wdata});
    end
    if (mem_re) begin
      mem_rdata <= ram[mem_addr];
      re_q.push_back(mem_addr);
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish within cycle budget");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference address sequencing from the mode rules.
  function automatic logic [15:0] nxt(input logic [15:0] a);
    case (model_mode[7:6])
      2'b00:   return a;
      2'b10:   return 16'((a / 32) * 32 + ((a % 32) + 1) % 32);
      default: return 16'((32'(a) + 1) % 65536);
    endcase
  endfunction

  task automatic sck_cycle(input logic [3:0] din, output logic [3:0] dout);
    sio_in = din;
    repeat (HALF) @(negedge clk);
    dout = sio_out;
    sck_in = 1'b1;
    repeat (HALF) @(negedge clk);
    sck_in = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    logic [3:0] d;
    if (quad_m) begin
      sck_cycle(tx[7:4], d); rx[7:4] = d;
      sck_cycle(tx[3:0], d); rx[3:0] = d;
    end else begin
      for (int i = 7; i >= 0; i--) begin
        sck_cycle({3'b000, tx[i]}, d);
        rx[i] = d[1];
      end
    end
  endtask

  task automatic cs_start();
    csb_in = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (HALF) @(negedge clk);
    csb_in = 1'b1;
    repeat (4 * HALF) @(negedge clk);
  endtask

  task automatic do_write(input logic [15:0] a, input int n, input string tag);
    logic [7:0]  rx, d;
    logic [15:0] ea;
    logic [23:0] exp_q[$];
    we_q.delete();
    ea = a;
    cs_start();
    xfer(8'h02, rx); xfer(a[15:8], rx); xfer(a[7:0], rx);
    for (int i = 0; i < n; i++) begin
      d = 8'($urandom);
      xfer(d, rx);
      exp_q.push_back({ea, d});
      exp_mem[ea] = d;
      ea = nxt(ea);
    end
    cs_end();
    chk({tag, " we count"}, we_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < we_q.size(); i++) begin
      chk({tag, " we addr"}, 32'(we_q[i][23:8]), 32'(exp_q[i][23:8]));
      chk({tag, " we data"}, 32'(we_q[i][7:0]), 32'(exp_q[i][7:0]));
    end
  endtask

  task automatic do_read(input logic [15:0] a, input int n, input string tag);
    logic [7:0]  rx;
    logic [15:0] ea;
    ea = a;
    cs_start();
    xfer(8'h03, rx); xfer(a[15:8], rx); xfer(a[7:0], rx);
    if (quad_m) xfer(8'h00, rx);
    for (int i = 0; i < n; i++) begin
      xfer(8'h00, rx);
      chk({tag, " rdata"}, 32'(rx), 32'(exp_mem[ea]));
      ea = nxt(ea);
    end
    cs_end();
  endtask

  task automatic do_wrmr(input logic [7:0] v);
    logic [7:0] rx;
    cs_start();
    xfer(8'h01, rx); xfer(v, rx);
    cs_end();
    model_mode = {v[7:6], 6'b0};
    chk("wrmr mode_reg", 32'(mode_reg), 32'(model_mode));
  endtask

  task automatic do_rdmr(input string tag);
    logic [7:0] rx;
    cs_start();
    xfer(8'h05, rx);
    xfer(8'h00, rx); chk({tag, " rdmr0"}, 32'(rx), 32'(model_mode));
    xfer(8'h00, rx); chk({tag, " rdmr1"}, 32'(rx), 32'(model_mode));
    cs_end();
  endtask

  initial begin
    logic [7:0]  rx;
    logic [3:0]  d;
    logic [15:0] a;
    for (int i = 0; i < 65536; i++) begin
      ram[i] = 8'($urandom);
      exp_mem[i] = ram[i];
    end
    reset = 1'b0; sck_in = 1'b0; csb_in = 1'b1; sio_in = 4'h0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst sio_out", 32'(sio_out), 0);
    chk("rst sio_oe", 32'(sio_oe), 0);
    chk("rst mem_we", 32'(mem_we), 0);
    chk("rst mem_re", 32'(mem_re), 0);
    chk("rst mem_addr", 32'(mem_addr), 0);
    chk("rst mem_wdata", 32'(mem_wdata), 0);
    chk("rst mode_reg", 32'(mode_reg), 32'h40);
    chk("rst busy", 32'(busy), 0);

    // Single write, fixed data.
    we_q.delete();
    cs_start();
    xfer(8'h02, rx); xfer(8'h12, rx); xfer(8'h34, rx); xfer(8'hA5, rx);
    cs_end();
    exp_mem[16'h1234] = 8'hA5;
    chk("wr1 count", we_q.size(), 1);
    if (we_q.size() > 0) begin
      chk("wr1 addr", 32'(we_q[0][23:8]), 32'h1234);
      chk("wr1 data", 32'(we_q[0][7:0]), 32'hA5);
    end

    // Sequential read across the top of the address space.
    ram[16'hFFFF] = 8'h11; exp_mem[16'hFFFF] = 8'h11;
    ram[16'h0000] = 8'h22; exp_mem[16'h0000] = 8'h22;
    re_q.delete();
    do_read(16'hFFFF, 2, "seqwrap");
    chk("seqwrap re count", 32'(re_q.size() >= 2), 1);
    if (re_q.size() >= 2) begin
      chk("seqwrap re0", 32'(re_q[0]), 32'hFFFF);
      chk("seqwrap re1", 32'(re_q[1]), 32'h0000);
    end

    do_rdmr("rst");
    do_wrmr(8'h80);
    do_rdmr("page");
    do_write(16'h001E, 3, "pagewrap");
    do_read(16'h001E, 3, "pagewrap");
    do_wrmr(8'h00);
    do_write(16'h0010, 2, "bytemode");

    // Write aborted after five data bits.
    do_wrmr(8'h40);
    we_q.delete();
    cs_start();
    xfer(8'h02, rx); xfer(8'h20, rx); xfer(8'h00, rx);
    for (int i = 0; i < 5; i++) sck_cycle(4'h1, d);
    cs_end();
    chk("abort we count", we_q.size(), 0);
    chk("abort state", 32'(dut.state), 32'(ssram_pkg::ST_IDLE));
    chk("abort busy", 32'(busy), 0);
    chk("abort sio_oe", 32'(sio_oe), 0);

    // WRMR cut short keeps the old mode.
    cs_start();
    xfer(8'h01, rx);
    for (int i = 0; i < 5; i++) sck_cycle(4'h1, d);
    cs_end();
    chk("short wrmr", 32'(mode_reg), 32'(model_mode));

    // Unknown opcode.
    cs_start();
    xfer(8'h9F, rx);
    for (int i = 0; i < 3; i++) begin
      sck_cycle(4'h0, d);
      chk("9F sio_oe", 32'(sio_oe), 0);
      chk("9F busy", 32'(busy), 0);
    end
    cs_end();

    // Randomized mix of mode changes, writes and reads.
    for (int t = 0; t < 14; t++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 2))
        0: a[4:0] = 5'd30;
        1: a = 16'hFFFE;
        default: ;
      endcase
      case ($urandom_range(0, 3))
        0: begin do_wrmr(8'($urandom)); do_rdmr("rnd"); end
        1, 2: do_write(a, $urandom_range(1, 3), "rnd");
        default: do_read(a, $urandom_range(1, 3), "rnd");
      endcase
    end

`ifdef SSRAM_SQI_EN
    do_wrmr(8'h40);
    cs_start(); xfer(8'h38, rx); cs_end();
    quad_m = 1'b1;
    do_write(16'h0456, 2, "quad");
    do_read(16'h0456, 2, "quad");
    do_rdmr("quad");
    cs_start(); xfer(8'hFF, rx); cs_end();
    quad_m = 1'b0;
    do_rdmr("spi again");
`endif

    // Reset in the middle of a read.
    do_wrmr(8'h80);
    cs_start();
    xfer(8'h03, rx); xfer(8'h12, rx); xfer(8'h34, rx);
    xfer(8'h00, rx);
    chk("midrd rdata", 32'(rx), 32'(exp_mem[16'h1234]));
    sck_cycle(4'h0, d);
    chk("midrd oe before", 32'(sio_oe), 32'h2);
    reset = 1'b0;
    #1;
    chk("midrd oe reset", 32'(sio_oe), 0);
    chk("midrd mode reset", 32'(mode_reg), 32'h40);
    csb_in = 1'b1; sck_in = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    model_mode = 8'h40;
    quad_m = 1'b0;
    repeat (4) @(negedge clk);
    do_rdmr("post reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
